// File: rtl/modaddsubred_pipe.sv
// rtl/modaddsubred_pipe.sv - multi-lane (a +/- b) mod MOD, fully reduced, 3-stage valid/ready pipeline
module modaddsubred_pipe #(
  parameter logic [63:0] MOD   = 64'h4_0008_0001,
  parameter int          IW    = 39,
  parameter int          OW    = 35,
  parameter int          LANES = 1,
  parameter int          TW    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_vld,
  output logic                o_rdy,
  input  logic                i_op,
  input  logic [TW-1:0]       i_tag,
  input  logic [LANES*IW-1:0] i_din_0,
  input  logic [LANES*IW-1:0] i_din_1,
  output logic                o_vld,
  input  logic                i_rdy,
  output logic [LANES*OW-1:0] o_dout,
  output logic [TW-1:0]       o_tag,
  output logic                o_busy
);
  localparam int XW = IW + 2;
  localparam int MW = IW + 1;
  localparam int K  = IW - OW + 1;
  localparam logic [XW-1:0] MOD_X = XW'(MOD);
  localparam logic [OW-1:0] MOD_O = OW'(MOD);

  logic en0, en1, en2;
  logic v0_d, v0_q, v1_d, v1_q, v2_d, v2_q;
  logic [LANES*XW-1:0] sm0_d, sm0_q;
  logic [LANES-1:0]    sgn1_d, sgn1_q;
  logic [LANES*OW-1:0] rem1_d, rem1_q;
  logic [LANES*OW-1:0] dout2_d, dout2_q;
  logic [TW-1:0]       tag0_d, tag0_q, tag1_d, tag1_q, tag2_d, tag2_q;

  // Returns {sign, |a op b|}; the magnitude always fits in IW+1 bits.
  function automatic logic [XW-1:0] signed_mag(input logic op, input logic [IW-1:0] a,
                                               input logic [IW-1:0] b);
    logic [XW-1:0] s;
    s = op ? ({2'b00, a} + {2'b00, b}) : ({2'b00, a} - {2'b00, b});
    return {s[XW-1], s[XW-1] ? MW'(-s) : MW'(s)};
  endfunction

  function automatic logic [OW-1:0] reduce(input logic [MW-1:0] mag);
    logic [XW-1:0] x;
    x = {1'b0, mag};
    for (int j = K; j >= 0; j--) begin
      if (x >= (MOD_X << j)) x = x - (MOD_X << j);
    end
    return OW'(x);
  endfunction

  // Negative residues fold to MOD - m, except an exact multiple which stays 0.
  function automatic logic [OW-1:0] fold_sign(input logic neg, input logic [OW-1:0] m);
    return (neg && m != '0) ? MOD_O - m : m;
  endfunction

  always_comb begin
    en2  = ~v2_q | i_rdy;
    en1  = ~v1_q | en2;
    en0  = ~v0_q | en1;
    v0_d = en0 ? i_vld : v0_q;
    v1_d = en1 ? v0_q  : v1_q;
    v2_d = en2 ? v1_q  : v2_q;
  end

  always_comb begin
    sm0_d  = sm0_q;
    tag0_d = tag0_q;
    if (en0 && i_vld) begin
      tag0_d = i_tag;
      for (int k = 0; k < LANES; k++) begin
        sm0_d[k*XW +: XW] = signed_mag(i_op, i_din_0[k*IW +: IW], i_din_1[k*IW +: IW]);
      end
    end
  end

  always_comb begin
    sgn1_d = sgn1_q;
    rem1_d = rem1_q;
    tag1_d = tag1_q;
    if (en1 && v0_q) begin
      tag1_d = tag0_q;
      for (int k = 0; k < LANES; k++) begin
        sgn1_d[k]          = sm0_q[k*XW + MW];
        rem1_d[k*OW +: OW] = reduce(sm0_q[k*XW +: MW]);
      end
    end
  end

  always_comb begin
    dout2_d = dout2_q;
    tag2_d  = tag2_q;
    if (en2 && v1_q) begin
      tag2_d = tag1_q;
      for (int k = 0; k < LANES; k++) begin
        dout2_d[k*OW +: OW] = fold_sign(sgn1_q[k], rem1_q[k*OW +: OW]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      sm0_q   <= '0;
      sgn1_q  <= '0;
      rem1_q  <= '0;
      dout2_q <= '0;
      tag0_q  <= '0;
      tag1_q  <= '0;
      tag2_q  <= '0;
    end else begin
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      sm0_q   <= sm0_d;
      sgn1_q  <= sgn1_d;
      rem1_q  <= rem1_d;
      dout2_q <= dout2_d;
      tag0_q  <= tag0_d;
      tag1_q  <= tag1_d;
      tag2_q  <= tag2_d;
    end
  end

  assign o_rdy  = en0;
  assign o_vld  = v2_q;
  assign o_dout = dout2_q;
  assign o_tag  = tag2_q;
  assign o_busy = v0_q | v1_q | v2_q;

endmodule

// File: tb/tb_modaddsubred_pipe.sv
// tb/tb_modaddsubred_pipe.sv - self-checking bench for modaddsubred_pipe against an integer residue model
module tb_modaddsubred_pipe;
  localparam int IW = 39;
  localparam int OW = 35;
  localparam int TW = 4;
  localparam int L4 = 4;
  localparam logic [63:0] MODP = 64'h4_0008_0001;
  localparam longint M = 64'h4_0008_0001;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          i_vld = 1'b0, o_rdy, i_op = 1'b0, o_vld, i_rdy = 1'b1, o_busy;
  logic [TW-1:0] i_tag = '0, o_tag;
  logic [IW-1:0] i_din_0 = '0, i_din_1 = '0;
  logic [OW-1:0] o_dout;

  logic             i_vld4 = 1'b0, o_rdy4, i_op4 = 1'b0, o_vld4, i_rdy4 = 1'b1, o_busy4;
  logic [TW-1:0]    i_tag4 = '0, o_tag4;
  logic [L4*IW-1:0] i_din4_0 = '0, i_din4_1 = '0;
  logic [L4*OW-1:0] o_dout4;

  modaddsubred_pipe #(.MOD(MODP), .IW(IW), .OW(OW), .LANES(1), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .o_rdy(o_rdy), .i_op(i_op), .i_tag(i_tag),
    .i_din_0(i_din_0), .i_din_1(i_din_1), .o_vld(o_vld), .i_rdy(i_rdy), .o_dout(o_dout),
    .o_tag(o_tag), .o_busy(o_busy));

  modaddsubred_pipe #(.MOD(MODP), .IW(IW), .OW(OW), .LANES(L4), .TW(TW)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_vld(i_vld4), .o_rdy(o_rdy4), .i_op(i_op4), .i_tag(i_tag4),
    .i_din_0(i_din4_0), .i_din_1(i_din4_1), .o_vld(o_vld4), .i_rdy(i_rdy4), .o_dout(o_dout4),
    .o_tag(o_tag4), .o_busy(o_busy4));

  int tests = 0;
  int fails = 0;
  logic [OW-1:0] exp_q[$];
  logic [TW-1:0] etag_q[$];
  logic [OW-1:0] pend_e = '0;
  logic          accepted = 1'b0;
  logic          held = 1'b0;
  logic [OW-1:0] held_dout = '0;
  logic [TW-1:0] held_tag = '0;
  int            rdy_low_seen = 0;
  int            sent = 0;
  logic [OW-1:0] exp4 [L4];

  function automatic logic [OW-1:0] ref_mod(input longint a, input longint b, input bit op);
    longint s, r;
    s = op ? a + b : a - b;
    r = s % M;
    if (r < 0) r = r + M;
    return OW'(r);
  endfunction

  function automatic logic [IW-1:0] rnd_operand();
    logic [63:0] r;
    longint v;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 3))
      0: v = longint'(r[IW-1:0]);
      1: v = longint'(r[7:0]);
      2: v = longint'(r[4:0]) * M + longint'($urandom_range(0, 2));
      default: v = (longint'(1) <<< IW) - 1 - longint'(r[1:0]);
    endcase
    return IW'(v);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: judge handshakes mid-cycle, update the scoreboard, return just after the edge.
  task automatic tick();
    @(negedge clk);
    accepted = i_vld && o_rdy;
    chk("o_rdy", o_rdy, !(exp_q.size() == 3 && !i_rdy));
    chk("o_busy", o_busy, exp_q.size() != 0);
    if (held) begin
      chk("hold_dout", o_dout, held_dout);
      chk("hold_tag", o_tag, held_tag);
    end
    held      = o_vld && !i_rdy;
    held_dout = o_dout;
    held_tag  = o_tag;
    if (!o_rdy) rdy_low_seen++;
    if (o_vld && i_rdy) begin
      if (exp_q.size() == 0) chk("unexpected_beat", o_vld, 1'b0);
      else begin
        chk("dout", o_dout, exp_q.pop_front());
        chk("tag", o_tag, etag_q.pop_front());
      end
    end
    if (accepted) begin
      exp_q.push_back(pend_e);
      etag_q.push_back(i_tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [IW-1:0] a, input logic [IW-1:0] b, input bit op,
                       input logic [TW-1:0] t, input logic [OW-1:0] e);
    i_vld = 1'b1; i_din_0 = a; i_din_1 = b; i_op = op; i_tag = t; pend_e = e;
  endtask

  task automatic send(input logic [IW-1:0] a, input logic [IW-1:0] b, input bit op,
                      input logic [TW-1:0] t, input logic [OW-1:0] e);
    drive(a, b, op, t, e);
    for (int n = 0; n < 50; n++) begin
      tick();
      if (accepted) break;
    end
    chk("accept_timeout", accepted, 1'b1);
    i_vld = 1'b0; i_din_0 = rnd_operand(); i_din_1 = rnd_operand(); i_tag = 4'hF;
  endtask

  task automatic drain();
    i_vld = 1'b0;
    i_rdy = 1'b1;
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) tick();
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  // Accept in the first cycle offered; result visible right after the third edge.
  task automatic lat_check(input logic [IW-1:0] a, input logic [IW-1:0] b, input bit op,
                           input logic [TW-1:0] t, input logic [OW-1:0] e);
    i_rdy = 1'b1;
    drive(a, b, op, t, e);
    tick();
    chk("lat_accept", accepted, 1'b1);
    i_vld = 1'b0;
    chk("lat_e1", o_vld, 1'b0);
    tick();
    chk("lat_e2", o_vld, 1'b0);
    tick();
    chk("lat_e3_vld", o_vld, 1'b1);
    chk("lat_e3_dout", o_dout, e);
    chk("lat_e3_tag", o_tag, t);
    drain();
  endtask

  task automatic beat4(input bit op);
    logic [L4*OW-1:0] d;
    i_vld4 = 1'b1; i_op4 = op; i_tag4 = 4'h9; i_rdy4 = 1'b1;
    @(negedge clk);
    chk("l4_rdy", o_rdy4, 1'b1);
    @(posedge clk); #1;
    i_vld4 = 1'b0;
    @(posedge clk); #1;
    chk("l4_early", o_vld4, 1'b0);
    @(posedge clk); #1;
    chk("l4_vld", o_vld4, 1'b1);
    chk("l4_tag", o_tag4, 4'h9);
    d = o_dout4;
    for (int k = 0; k < L4; k++) chk($sformatf("l4_lane%0d", k), d[k*OW +: OW], exp4[k]);
  endtask

  initial begin
    logic [IW-1:0] a, b;
    bit op;
    logic [IW-1:0] ones;
    ones = '1;

    i_rdy = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_vld", o_vld, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_dout", o_dout, '0);
    chk("rst_tag", o_tag, '0);
    chk("rst_rdy", o_rdy, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    lat_check(39'd5, 39'd3, 1'b0, 4'hA, 35'd2);

    i_rdy = 1'b1;
    send(39'd3, 39'd5, 1'b0, 4'h1, 35'h4_0007_FFFF);
    send(IW'(M), IW'(2 * M), 1'b0, 4'h2, 35'd0);
    send(IW'(31 * M + 7), 39'd0, 1'b1, 4'h3, 35'd7);
    send(ones, ones, 1'b1, 4'h4, ref_mod(longint'(ones), longint'(ones), 1'b1));
    drain();

    sent = 0;
    rdy_low_seen = 0;
    for (int c = 0; c < 40 && (sent < 6 || exp_q.size() != 0); c++) begin
      i_rdy = !(c >= 2 && c <= 6);
      i_vld = (sent < 6);
      a = rnd_operand(); b = rnd_operand(); op = 1'($urandom_range(0, 1));
      i_din_0 = a; i_din_1 = b; i_op = op; i_tag = TW'(sent + 5);
      pend_e = ref_mod(longint'(a), longint'(b), op);
      tick();
      if (accepted) sent++;
    end
    chk("stall_sent", sent, 6);
    chk("stall_drained", exp_q.size(), 0);
    chk("stall_rdy_dropped", rdy_low_seen > 0, 1'b1);
    drain();

    for (int c = 0; c < 3000; c++) begin
      i_rdy = ($urandom_range(0, 3) != 0);
      i_vld = ($urandom_range(0, 3) != 0);
      a = rnd_operand(); b = rnd_operand(); op = 1'($urandom_range(0, 1));
      i_din_0 = a; i_din_1 = b; i_op = op; i_tag = TW'($urandom_range(0, 15));
      pend_e = ref_mod(longint'(a), longint'(b), op);
      tick();
    end
    drain();

    i_rdy = 1'b0;
    send(39'd11, 39'd1, 1'b1, 4'h6, 35'd12);
    send(39'd1, 39'd11, 1'b0, 4'h7, ref_mod(1, 11, 1'b0));
    send(39'd20, 39'd20, 1'b0, 4'h8, 35'd0);
    i_vld = 1'b1;
    tick();
    chk("full_refuses", accepted, 1'b0);
    i_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", o_vld, 1'b0);
    chk("mid_rst_dout", o_dout, '0);
    chk("mid_rst_busy", o_busy, 1'b0);
    chk("mid_rst_rdy", o_rdy, 1'b1);
    exp_q.delete();
    etag_q.delete();
    held = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    lat_check(IW'(3 * M + 4), 39'd9, 1'b0, 4'hC, ref_mod(3 * M + 4, 9, 1'b0));
    for (int n = 0; n < 5; n++) tick();

    i_din4_0[0*IW +: IW] = 39'd100;      i_din4_1[0*IW +: IW] = 39'd1;
    i_din4_0[1*IW +: IW] = 39'd1;        i_din4_1[1*IW +: IW] = 39'd100;
    i_din4_0[2*IW +: IW] = 39'd7;        i_din4_1[2*IW +: IW] = 39'd7;
    i_din4_0[3*IW +: IW] = IW'(M);       i_din4_1[3*IW +: IW] = IW'(4 * M);
    exp4[0] = 35'd99;
    exp4[1] = OW'(M - 99);
    exp4[2] = 35'd0;
    exp4[3] = 35'd0;
    beat4(1'b0);
    for (int k = 0; k < L4; k++) begin
      a = (k == 3) ? ones : rnd_operand();
      b = (k == 3) ? ones : rnd_operand();
      i_din4_0[k*IW +: IW] = a;
      i_din4_1[k*IW +: IW] = b;
      exp4[k] = ref_mod(longint'(a), longint'(b), 1'b1);
    end
    beat4(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
